// File: rtl/exe_mem_skid_reg_if.sv
// -----------------------------------------------------------------------------
// exe_mem_skid_reg_if
// Bundle of every signal crossing the EXE -> MEM boundary register.
//   slave  modport : the boundary register (consumes exe_*, mem_ready;
//                    produces exe_ready, mem_*, fwd_*, load_pending)
//   master modport : the surrounding pipeline / environment
// Handshake: a transfer on either side happens on the rising clock edge
// where valid and ready are both 1 (EXE side additionally requires
// exe_busy = 0). Valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
interface exe_mem_skid_reg_if #(
    parameter int DATA_WIDTH = 64,
    parameter int PC_WIDTH   = 64,
    parameter int RD_WIDTH   = 5
);
    // EXE side
    logic                  exe_valid;
    logic                  exe_busy;
    logic                  exe_ready;
    logic [PC_WIDTH-1:0]   exe_pc;
    logic [DATA_WIDTH-1:0] exe_result;
    logic [DATA_WIDTH-1:0] exe_store_data;
    logic [RD_WIDTH-1:0]   exe_rd;
    logic                  exe_rd_wen;
    logic                  exe_mem_ren;
    logic                  exe_mem_wen;
    logic [2:0]            exe_mem_func3;

    // MEM side
    logic                  mem_valid;
    logic                  mem_ready;
    logic [PC_WIDTH-1:0]   mem_pc;
    logic [DATA_WIDTH-1:0] mem_result;
    logic [DATA_WIDTH-1:0] mem_store_data;
    logic [RD_WIDTH-1:0]   mem_rd;
    logic                  mem_rd_wen;
    logic                  mem_mem_ren;
    logic                  mem_mem_wen;
    logic [2:0]            mem_mem_func3;

    // Forwarding / hazard information for ID/EXE
    logic                  fwd_valid;
    logic [RD_WIDTH-1:0]   fwd_rd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  load_pending;

    modport slave (
        input  exe_valid, exe_busy, exe_pc, exe_result, exe_store_data,
               exe_rd, exe_rd_wen, exe_mem_ren, exe_mem_wen, exe_mem_func3,
               mem_ready,
        output exe_ready,
               mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
               mem_rd_wen, mem_mem_ren, mem_mem_wen, mem_mem_func3,
               fwd_valid, fwd_rd, fwd_data, load_pending
    );

    modport master (
        output exe_valid, exe_busy, exe_pc, exe_result, exe_store_data,
               exe_rd, exe_rd_wen, exe_mem_ren, exe_mem_wen, exe_mem_func3,
               mem_ready,
        input  exe_ready,
               mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
               mem_rd_wen, mem_mem_ren, mem_mem_wen, mem_mem_func3,
               fwd_valid, fwd_rd, fwd_data, load_pending
    );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_skid_reg
// EXE -> MEM pipeline register built as a 2-entry skid buffer (output slot
// plus skid slot). EXE can retire one instruction per cycle while MEM stalls,
// and exe_ready comes straight from a flop so MEM's ready never reaches EXE
// combinationally.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears everything
//   flush  - synchronous kill of both slots (redirect / trap)
//   bus    - slave side of exe_mem_skid_reg_if (EXE handshake + payload,
//            MEM handshake + payload, forwarding / load-use outputs)
// -----------------------------------------------------------------------------
module exe_mem_skid_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int PC_WIDTH   = 64,
    parameter int RD_WIDTH   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    exe_mem_skid_reg_if.slave    bus
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [RD_WIDTH-1:0]   rd;
        logic                  rd_wen;
        logic                  mem_ren;
        logic                  mem_wen;
        logic [2:0]            mem_func3;
    } payload_t;

    payload_t in_pl;
    payload_t out_q,  out_d;
    payload_t skid_q, skid_d;
    logic     out_valid_q,  out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     accept;
    logic     consume;

    always_comb begin
        in_pl            = '0;
        in_pl.pc         = bus.exe_pc;
        in_pl.result     = bus.exe_result;
        in_pl.store_data = bus.exe_store_data;
        in_pl.rd         = bus.exe_rd;
        in_pl.rd_wen     = bus.exe_rd_wen;
        in_pl.mem_ren    = bus.exe_mem_ren;
        in_pl.mem_wen    = bus.exe_mem_wen;
        in_pl.mem_func3  = bus.exe_mem_func3;
    end

    // Ready only depends on the skid flop; busy results are never captured.
    assign accept  = bus.exe_valid & ~bus.exe_busy & ~skid_valid_q;
    assign consume = out_valid_q & bus.mem_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            // Payload left stale; everything downstream gates on valid.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                // Skid entry is older than anything upstream, so it moves
                // first. accept is impossible here because exe_ready = 0.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_pl;
                end
            end
        end else if (accept) begin
            // Output slot stalled: park the new result in the skid slot.
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.exe_ready      = ~skid_valid_q;
    assign bus.mem_valid      = out_valid_q;
    assign bus.mem_pc         = out_q.pc;
    assign bus.mem_result     = out_q.result;
    assign bus.mem_store_data = out_q.store_data;
    assign bus.mem_rd         = out_q.rd;
    assign bus.mem_rd_wen     = out_q.rd_wen;
    assign bus.mem_mem_ren    = out_q.mem_ren;
    assign bus.mem_mem_wen    = out_q.mem_wen;
    assign bus.mem_mem_func3  = out_q.mem_func3;

    // Only the output slot is visible to forwarding; x0 is never a hazard.
    assign bus.fwd_valid    = out_valid_q & out_q.rd_wen & (out_q.rd != '0) & ~out_q.mem_ren;
    assign bus.fwd_rd       = out_q.rd;
    assign bus.fwd_data     = out_q.result;
    assign bus.load_pending = out_valid_q & out_q.mem_ren & out_q.rd_wen & (out_q.rd != '0);

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
module tb_exe_mem_skid_reg;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  mem_func3;
    } item_t;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    logic flush;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exe_mem_skid_reg_if bus ();

    exe_mem_skid_reg dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    item_t exp_q[$];
    int    total;
    int    bad;
    int    pops;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [63:0] pc, input logic [63:0] res,
                                 input logic [63:0] sd, input logic [4:0] rd,
                                 input logic wen, input logic ren, input logic mwen,
                                 input logic [2:0] f3);
        item_t it;
        it.pc = pc; it.result = res; it.store_data = sd; it.rd = rd;
        it.rd_wen = wen; it.mem_ren = ren; it.mem_wen = mwen; it.mem_func3 = f3;
        return it;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        item_t act;
        item_t exp;
        if (reset && bus.mem_valid && bus.mem_ready) begin
            act = mk(bus.mem_pc, bus.mem_result, bus.mem_store_data, bus.mem_rd,
                     bus.mem_rd_wen, bus.mem_mem_ren, bus.mem_mem_wen, bus.mem_mem_func3);
            total++;
            pops++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected: got pc=0x%0h expected no output", act.pc);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL mon_payload: got 0x%0h expected 0x%0h", act, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_fields(input item_t it);
        bus.exe_pc         = it.pc;
        bus.exe_result     = it.result;
        bus.exe_store_data = it.store_data;
        bus.exe_rd         = it.rd;
        bus.exe_rd_wen     = it.rd_wen;
        bus.exe_mem_ren    = it.mem_ren;
        bus.exe_mem_wen    = it.mem_wen;
        bus.exe_mem_func3  = it.mem_func3;
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input item_t it, output int waits);
        logic r;
        exp_q.push_back(it);
        drive_fields(it);
        bus.exe_valid = 1'b1;
        waits = 0;
        r = 1'b0;
        while (!r && waits < 50) begin
            @(negedge clock);
            r = bus.exe_ready;
            @(posedge clock);
            waits++;
        end
        if (!r) check_val("send_timeout", 64'(waits), 64'd0);
        #1;
        bus.exe_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int w2;
        int w3;
        item_t a, b, c;
        total = 0; bad = 0; pops = 0;

        // Reset held with a valid instruction on the input.
        reset = 1'b0; flush = 1'b0; bus.mem_ready = 1'b0; bus.exe_busy = 1'b0;
        drive_fields(mk(64'h1111, 64'h2222, 64'h3333, 5'd7, 1'b1, 1'b0, 1'b0, 3'd3));
        bus.exe_valid = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check_val("rst_exe_ready", 64'(bus.exe_ready), 64'd1);
        check_val("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        check_val("rst_load_pend", 64'(bus.load_pending), 64'd0);
        check_val("rst_mem_pc", bus.mem_pc, 64'd0);
        reset = 1'b1;
        bus.exe_valid = 1'b0;
        @(posedge clock); #1;

        // First instruction: visible one edge after accept.
        send(mk(64'h8000_0000, 64'h10, 64'h20, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0), w);
        @(negedge clock);
        check_val("first_mem_valid", 64'(bus.mem_valid), 64'd1);
        check_val("first_mem_pc", bus.mem_pc, 64'h8000_0000);
        @(posedge clock); #1;
        bus.mem_ready = 1'b1;
        drain();

        // Streaming at full rate.
        a = mk(64'hA000, 64'hAAAA, 64'h0A, 5'd10, 1'b1, 1'b0, 1'b0, 3'd1);
        b = mk(64'hB000, 64'hBBBB, 64'h0B, 5'd11, 1'b0, 1'b0, 1'b1, 3'd2);
        c = mk(64'hC000, 64'hCCCC, 64'h0C, 5'd12, 1'b1, 1'b1, 1'b0, 3'd4);
        pops = 0;
        send(a, w); check_val("stream_wait_a", 64'(w), 64'd1);
        send(b, w); check_val("stream_wait_b", 64'(w), 64'd1);
        send(c, w); check_val("stream_wait_c", 64'(w), 64'd1);
        drain();
        check_val("stream_pops", 64'(pops), 64'd3);

        // Backpressure: A in out, B in skid, C stalled upstream.
        bus.mem_ready = 1'b0;
        a.pc = 64'hA100; b.pc = 64'hB100; c.pc = 64'hC100;
        fork
            begin
                send(a, w); send(b, w2); send(c, w3);
            end
            begin
                repeat (3) @(negedge clock);
                check_val("bp_mem_pc", bus.mem_pc, 64'hA100);
                check_val("bp_exe_ready", 64'(bus.exe_ready), 64'd0);
                check_val("bp_queue", 64'(exp_q.size()), 64'd3);
                @(posedge clock); #1;
                bus.mem_ready = 1'b1;
            end
        join
        check_val("bp_wait_b", 64'(w2), 64'd1);
        check_val("bp_wait_c_stalled", 64'(w3 > 1), 64'd1);
        drain();

        // Busy: nothing captured while exe_busy=1.
        bus.mem_ready = 1'b0;
        send(mk(64'hD000, 64'hDDDD, 64'h0D, 5'd13, 1'b1, 1'b0, 1'b0, 3'd0), w);
        drive_fields(mk(64'hE000, 64'hEEEE, 64'h0E, 5'd14, 1'b1, 1'b0, 1'b0, 3'd5));
        bus.exe_valid = 1'b1;
        bus.exe_busy  = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_val("busy_mem_valid", 64'(bus.mem_valid), 64'd0);
        check_val("busy_exe_ready", 64'(bus.exe_ready), 64'd1);
        @(posedge clock); #1;
        exp_q.push_back(mk(64'hE000, 64'hEEEE, 64'h0E, 5'd14, 1'b1, 1'b0, 1'b0, 3'd5));
        bus.exe_busy = 1'b0;
        @(posedge clock); #1;
        bus.exe_valid = 1'b0;
        @(negedge clock);
        check_val("unbusy_mem_pc", bus.mem_pc, 64'hE000);
        drain();

        // Flush with both slots full and a new valid on the input.
        bus.mem_ready = 1'b0;
        send(mk(64'hF000, 64'h1, 64'h2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0), w);
        send(mk(64'hF100, 64'h3, 64'h4, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0), w);
        check_val("flush_pre_queue", 64'(exp_q.size()), 64'd2);
        drive_fields(mk(64'hF200, 64'h5, 64'h6, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0));
        bus.exe_valid = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        bus.exe_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check_val("flush_mem_valid", 64'(bus.mem_valid), 64'd0);
        check_val("flush_exe_ready", 64'(bus.exe_ready), 64'd1);
        @(posedge clock); #1;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("flush_stays_empty", 64'(bus.mem_valid), 64'd0);
        @(posedge clock); #1;

        // Forwarding / load-use decode of the output slot.
        bus.mem_ready = 1'b0;
        send(mk(64'h100, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0), w);
        @(negedge clock);
        check_val("fwd_valid_rd5", 64'(bus.fwd_valid), 64'd1);
        check_val("fwd_data_rd5", bus.fwd_data, 64'h1234);
        check_val("fwd_rd_rd5", 64'(bus.fwd_rd), 64'd5);
        check_val("lp_rd5", 64'(bus.load_pending), 64'd0);
        @(posedge clock); #1; bus.mem_ready = 1'b1;
        @(posedge clock); #1; bus.mem_ready = 1'b0;

        send(mk(64'h104, 64'h5678, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0), w);
        @(negedge clock);
        check_val("fwd_valid_rd0", 64'(bus.fwd_valid), 64'd0);
        check_val("rd_wen_rd0", 64'(bus.mem_rd_wen), 64'd1);
        @(posedge clock); #1; bus.mem_ready = 1'b1;
        @(posedge clock); #1; bus.mem_ready = 1'b0;

        send(mk(64'h108, 64'h9ABC, 64'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'd2), w);
        @(negedge clock);
        check_val("fwd_valid_load", 64'(bus.fwd_valid), 64'd0);
        check_val("lp_load", 64'(bus.load_pending), 64'd1);
        @(posedge clock); #1; bus.mem_ready = 1'b1;
        drain();

        // Asynchronous reset while both slots hold entries.
        bus.mem_ready = 1'b0;
        send(mk(64'h200, 64'h1, 64'h1, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0), w);
        send(mk(64'h204, 64'h2, 64'h2, 5'd7, 1'b1, 1'b1, 1'b0, 3'd0), w);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check_val("arst_exe_ready", 64'(bus.exe_ready), 64'd1);
        check_val("arst_mem_pc", bus.mem_pc, 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
Pipeline boundary between the EXE stage (ALU and mul/div) and the MEM stage. It captures one retired EXE result per cycle into a 2-entry skid buffer (output slot plus skid slot). This lets EXE run at full rate while MEM applies backpressure, with no combinational ready path from MEM back to EXE. It also publishes forwarding and load-use information for the output slot back to the ID/EXE operand muxes.

Parameters:
DATA_WIDTH, 64, width of the ALU result and store data
PC_WIDTH, 64, width of the instruction address
RD_WIDTH, 5, destination register index width

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
flush  in  1  synchronous kill of all held entries (redirect/trap)
exe_valid  in  1  EXE presents a completed instruction
exe_busy  in  1  ALU multi-cycle op in progress; result not final
exe_ready  out  1  buffer can accept this cycle (registered: !skid_valid)
exe_pc  in  PC_WIDTH  instruction PC
exe_result  in  DATA_WIDTH  ALU result / effective address
exe_store_data  in  DATA_WIDTH  rs2 data for stores
exe_rd  in  RD_WIDTH  destination register
exe_rd_wen  in  1  writes rd
exe_mem_ren  in  1  load
exe_mem_wen  in  1  store
exe_mem_func3  in  3  access size/sign
mem_valid  out  1  output slot holds a valid instruction
mem_ready  in  1  MEM consumes the output slot this cycle
mem_pc, mem_result, mem_store_data, mem_rd, mem_rd_wen, mem_mem_ren, mem_mem_wen, mem_mem_func3  out  as inputs  output-slot fields
fwd_valid  out  1  output slot valid & rd_wen & rd!=0 & !mem_ren
fwd_rd  out  RD_WIDTH  output-slot rd
fwd_data  out  DATA_WIDTH  output-slot result
load_pending  out  1  output slot valid & mem_ren & rd_wen & rd!=0

Behaviour:
- Reset (reset=0, async): out_valid=0, skid_valid=0, all payload registers=0. So mem_valid=0, exe_ready=1, fwd_valid=0, load_pending=0. Reset asserted mid-transfer drops every entry, with no partial outputs.
- accept = exe_valid & !exe_busy & exe_ready. exe_busy=1 never captures, even when exe_valid=1.
- consume = out_valid & mem_ready.
- Per-cycle update, when flush=0:
  - out empty or consume, skid empty: out <= incoming if accept, else out_valid <= 0.
  - out empty or consume, skid full: out <= skid; skid <= incoming if accept, else skid_valid <= 0. Accept cannot occur here, because exe_ready=0.
  - out full and !consume: out holds. If accept, skid <= incoming.
- Order is strictly FIFO: the skid entry always precedes any newer entry.
- exe_ready = !skid_valid, driven from a register. There is no combinational path from mem_ready to exe_ready.
- Latency: accept at edge N gives mem_valid at N+1 when the output slot was free. Throughput is 1/cycle while mem_ready=1.
- flush=1: out_valid<=0 and skid_valid<=0 at the next edge. Flush overrides accept and consume. Payload registers may hold stale data; consumers gate on the valid bits.
- Payload registers load only on capture, to save toggling.
- Forwarding outputs are combinational decodes of the output slot only; the skid slot is never forwarded.
- When exe_rd=0, rd_wen passes through unchanged; the rd!=0 gating is applied only on the fwd/load_pending outputs.
- exe_mem_ren and exe_mem_wen both 1 is illegal upstream. Fields pass through unmodified and nothing is checked.

Test Plan:
- Reset: drive reset=0 for 2 cycles while exe_valid=1 -> mem_valid=0, exe_ready=1. After release, exe_valid with pc=0x80000000 -> mem_valid=1 and mem_pc=0x80000000 one edge later.
- Streaming: mem_ready=1; send A,B,C on consecutive cycles -> mem_valid=1 on 3 consecutive cycles, order A,B,C, exe_ready stays 1.
- Backpressure: mem_ready=0 for 3 cycles while streaming A,B,C -> A held in out, B in skid, exe_ready=0 and C held upstream. Set mem_ready=1 -> A,B,C delivered in order, with no loss or duplication.
- Busy: exe_valid=1, exe_busy=1 for 5 cycles -> nothing captured, mem_valid falls to 0 after the held entry is consumed. exe_busy=0 -> result captured next edge.
- Flush: out and skid full, exe_valid=1, flush=1 -> next cycle mem_valid=0, skid empty, exe_ready=1, incoming dropped.
- Forwarding: output slot with rd=5, rd_wen=1, ren=0, result=0x1234 -> fwd_valid=1, fwd_data=0x1234. Set rd=0 -> fwd_valid=0. Set ren=1, rd=5 -> fwd_valid=0, load_pending=1.
